// File: rtl/divide_pkg.sv
// Shared definitions for the shift-subtract divider: FSM states and default width.
package divide_pkg;

  localparam int DIV_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divide_step.sv
// One restoring-division step: shift in the next dividend bit, then compare-subtract.
module divide_step
  import divide_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   rem,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_next,
  output logic         q_bit
);

  logic [N:0] shifted;

  // A set top bit means the shifted value exceeds N+1 bits, so it is larger
  // than any divisor; the modular subtraction below still yields the right remainder.
  assign shifted  = {rem[N-1:0], bit_in};
  assign q_bit    = rem[N] | (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/divide_shift_sub.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per cycle.
module divide_shift_sub
  import divide_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] Z,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  logic [N:0]    rem;
  logic [N-1:0]  z_lo;
  logic [N-1:0]  divisor;
  logic [N-1:0]  q_acc;
  logic [CW-1:0] cnt;

  logic [N:0]    rem_next;
  logic          q_bit;
  logic [N-1:0]  q_next;

  divide_step #(.N(N)) u_step (
    .rem      (rem),
    .bit_in   (z_lo[cnt]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    q_next      = q_acc;
    q_next[cnt] = q_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      err     <= 1'b0;
      rem     <= '0;
      z_lo    <= '0;
      divisor <= '0;
      q_acc   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            z_lo    <= Z[N-1:0];
            divisor <= B;
            busy    <= 1'b1;
            // A high half not below the divisor means divide-by-zero or a quotient wider than N bits.
            if (Z[2*N-1:N] >= B) begin
              Q     <= '1;
              R     <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rem   <= {1'b0, Z[2*N-1:N]};
              cnt   <= CW'(N - 1);
              q_acc <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_next;
          q_acc <= q_next;
          if (cnt == '0) begin
            Q     <= q_next;
            R     <= rem_next[N-1:0];
            err   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_shift_sub.sv
// Randomized and directed check of divide_shift_sub against an arithmetic division model.
module tb_divide_shift_sub;

  localparam int N = 4;
  localparam int QMAX = (1 << N) - 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*N-1:0] Z;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [N-1:0]   Q;
  logic [N-1:0]   R;
  logic           err;

  int vectors;
  int miscompares;

  divide_shift_sub #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Z     (Z),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Plain integer division; overflow whenever the true quotient needs more than N bits.
  task automatic modelDivide(input int z, input int b, output int q, output int r, output int e);
    if (b == 0 || (z / b) > QMAX) begin
      q = QMAX;
      r = 0;
      e = 1;
    end else begin
      q = z / b;
      r = z % b;
      e = 0;
    end
  endtask

  // Issues one division at posedge+1 and follows it to completion plus one idle cycle.
  // Latency is counted in rising edges after the accept edge; an error result is
  // already registered by the accept edge itself.
  task automatic applyStimulus(input int z, input int b, input bit intrude);
    int q, r, e, edges;
    modelDivide(z, b, q, r, e);
    Z     = 8'(z);
    B     = 4'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    Z     = 8'($urandom);
    B     = 4'($urandom);
    edges = 0;
    while (!done && edges < 20) begin
      if (intrude && edges == 1) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
    end
    checkOutput("done_seen", 32'(done), 1);
    checkOutput("latency", edges, (e != 0) ? 0 : N);
    checkOutput("busy_in_done", 32'(busy), 1);
    checkOutput("Q", 32'(Q), q);
    checkOutput("R", 32'(R), r);
    checkOutput("err", 32'(err), e);
    if (e == 0) checkOutput("identity", 32'(Q) * 32'(b) + 32'(R), z);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_end", 32'(done), 0);
    checkOutput("busy_idle", 32'(busy), 0);
    checkOutput("Q_hold", 32'(Q), q);
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    Z     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_Q", 32'(Q), 0);
    checkOutput("reset_R", 32'(R), 0);
    checkOutput("reset_err", 32'(err), 0);
    rst = 1'b0;

    applyStimulus(143, 13, 1'b0);
    applyStimulus(100, 7, 1'b0);
    applyStimulus(225, 15, 1'b0);
    applyStimulus(5, 0, 1'b0);
    applyStimulus(8'h50, 5, 1'b0);
    applyStimulus(0, 1, 1'b0);
    applyStimulus(255, 1, 1'b0);

    // A second request during CALC must not disturb the first one.
    applyStimulus(143, 13, 1'b1);
    watchNoDone("no_extra_done", 8);

    // Abort during the second CALC cycle.
    Z     = 8'd100;
    B     = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_Q", 32'(Q), 0);
    checkOutput("abort_R", 32'(R), 0);
    checkOutput("abort_err", 32'(err), 0);
    watchNoDone("abort_no_done", 8);
    applyStimulus(100, 7, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int b, a, r;
      if (i % 2 == 0) begin
        applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b0);
      end else begin
        b = int'($urandom_range(1, 15));
        a = int'($urandom_range(0, 15));
        r = int'($urandom_range(0, b - 1));
        applyStimulus(a * b + r, b, 1'b0);
      end
    end

    for (int a = 0; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        applyStimulus(a * b, b, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
